// File: rtl/om_pkg.sv
// Shared definitions for the online-multiplier operand feeder: signed-digit
// encodings, controller states and the QM initial-value helper.
package om_pkg;

    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } om_state_e;

    // -1 in a (wl+1)-bit two's-complement fraction: only the sign bit set.
    // Callers slice the low wl+1 bits of the result.
    function automatic logic [63:0] qm_init(input int unsigned wl);
        return 64'd1 << wl;
    endfunction

endpackage

// File: rtl/om_otfc.sv
// One digit-serial on-the-fly converter: keeps Q (value so far) and QM (Q minus
// one ulp of the current digit), appending a signed digit without carry ripple.
module om_otfc
    import om_pkg::*;
#(
    parameter int WL = 8,
    parameter int IW = $clog2(WL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  logic [1:0]    digit,
    input  logic [IW-1:0] idx,
    output logic [WL:0]   q_before,
    output logic [WL:0]   q_after
);

    localparam logic [63:0] QM_INIT_W = qm_init(WL);
    localparam logic [WL:0] QM_INIT   = QM_INIT_W[WL:0];

    logic [WL:0] q;
    logic [WL:0] qm;
    logic [WL:0] qm_after;
    logic [WL:0] bit_k;

    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        bit_k    = (WL + 1)'(1) << idx;
        q_after  = q;
        qm_after = qm;
        case (digit)
            SD_POS: begin
                q_after  = q | bit_k;
                qm_after = q;
            end
            SD_NEG: begin
                q_after  = qm | bit_k;
                qm_after = qm;
            end
            // Zero and the illegal code both append a zero digit.
            default: begin
                q_after  = q;
                qm_after = qm | bit_k;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= '0;
            qm <= QM_INIT;
        end else if (clear) begin
            q  <= '0;
            qm <= QM_INIT;
        end else if (en) begin
            q  <= q_after;
            qm <= qm_after;
        end
    end

    assign q_before = q;

endmodule

// File: rtl/om_operand_otfc.sv
// Operand feeder for the radix-2 online multiplier: converts the X and Y digit
// streams to two's complement and emits aligned beats plus DELTA flush beats.
// Optional illegal-digit detection is built when OM_ILLEGAL_CHK_EN is defined.
module om_operand_otfc
    import om_pkg::*;
#(
    parameter int WL_XY = 8,
    parameter int DELTA = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       x_in,
    input  logic [1:0]       y_in,
    output logic             out_valid,
    output logic [1:0]       x_d,
    output logic [1:0]       y_d,
    output logic [WL_XY:0]   xY_out,
    output logic [WL_XY:0]   yX_out,
    output logic             last,
    output logic             busy,
    output logic             err
);

    localparam int IW = $clog2(WL_XY + 1);
    localparam int FW = $clog2(DELTA + 1);

    om_state_e       state, state_next;
    logic [IW-1:0]   j;
    logic [FW-1:0]   fcnt;
    logic            accept;
    logic            flush_beat;
    logic            flush_last;
    logic [IW-1:0]   idx;
    logic [1:0]      x_dig;
    logic [1:0]      y_dig;
    logic [WL_XY:0]  qx_before, qx_after;
    logic [WL_XY:0]  qy_before, qy_after;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        flush_beat = 1'b0;
        case (state)
            IDLE: ;
            LOAD: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (j == IW'(WL_XY)) state_next = FLUSH;
                end
            end
            FLUSH: begin
                flush_beat = 1'b1;
                if (fcnt == FW'(DELTA - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // start overrides everything: abort, no beat, the digit is dropped.
        if (start) begin
            state_next = LOAD;
            accept     = 1'b0;
            flush_beat = 1'b0;
        end
    end

    assign flush_last = flush_beat && (fcnt == FW'(DELTA - 1));
    assign idx        = IW'(WL_XY) - j;
    // Converters only see a digit when one is accepted, so outside accept
    // cycles q_after equals q_before.
    assign x_dig      = accept ? x_in : SD_ZERO;
    assign y_dig      = accept ? y_in : SD_ZERO;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j    <= '0;
            fcnt <= '0;
        end else if (start) begin
            j    <= IW'(1);
            fcnt <= '0;
        end else begin
            if (accept && (j != IW'(WL_XY))) j <= j + IW'(1);
            if (flush_beat) fcnt <= fcnt + FW'(1);
        end
    end

    om_otfc #(.WL(WL_XY), .IW(IW)) u_conv_x (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .en       (accept),
        .digit    (x_dig),
        .idx      (idx),
        .q_before (qx_before),
        .q_after  (qx_after)
    );

    om_otfc #(.WL(WL_XY), .IW(IW)) u_conv_y (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .en       (accept),
        .digit    (y_dig),
        .idx      (idx),
        .q_before (qy_before),
        .q_after  (qy_after)
    );

    // Beat register: X is presented before its append, Y after, matching the
    // X[j-1]*y_j + Y[j]*x_j terms of the online recurrence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            last      <= 1'b0;
            x_d       <= '0;
            y_d       <= '0;
            yX_out    <= '0;
            xY_out    <= '0;
        end else begin
            out_valid <= accept | flush_beat;
            last      <= flush_last;
            if (accept) begin
                x_d    <= x_in;
                y_d    <= y_in;
                yX_out <= qx_before;
                xY_out <= qy_after;
            end else if (flush_beat) begin
                x_d    <= SD_ZERO;
                y_d    <= SD_ZERO;
                yX_out <= qx_after;
                xY_out <= qy_before;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign in_ready = (state == LOAD);

`ifdef OM_ILLEGAL_CHK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (start)
            err_q <= 1'b0;
        else if (accept && ((x_in == SD_ILL) || (y_in == SD_ILL)))
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_om_operand_otfc.sv
// Directed bench for om_operand_otfc (WL_XY=8, DELTA=2) with hand-computed
// operand values per beat.
module tb_om_operand_otfc;
    import om_pkg::*;

    localparam int WL    = 8;
    localparam int DELTA = 2;
`ifdef OM_ILLEGAL_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    x_in, y_in;
    logic          out_valid;
    logic [1:0]    x_d, y_d;
    logic [WL:0]   xY_out, yX_out;
    logic          last, busy, err;

    int vectors     = 0;
    int miscompares = 0;

    om_operand_otfc #(.WL_XY(WL), .DELTA(DELTA)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .x_d       (x_d),
        .y_d       (y_d),
        .xY_out    (xY_out),
        .yX_out    (yX_out),
        .last      (last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic s, input logic v, input logic [1:0] x, input logic [1:0] y);
        start = s; in_valid = v; x_in = x; y_in = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; in_valid = 1'b0; x_in = SD_ZERO; y_in = SD_ZERO;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, last, busy, in_ready, err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: out_valid/last/busy/in_ready/err=%b want 00000", {out_valid, last, busy, in_ready, err});
        end
        vectors++;
        if ({x_d, y_d, xY_out, yX_out} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: x_d=%b y_d=%b xY=%h yX=%h want all 0", x_d, y_d, xY_out, yX_out);
        end
        rst = 1'b0;
        cyc(0, 1, SD_POS, SD_POS);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_in_valid: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_basic();
        logic [WL:0] exp_yx;
        logic [1:0]  dig;
        cyc(1, 0, SD_ZERO, SD_ZERO);
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_start: busy=%b in_ready=%b out_valid=%b want 1 1 0", busy, in_ready, out_valid);
        end
        for (int k = 1; k <= WL; k++) begin
            dig    = (k == 1) ? SD_POS : SD_ZERO;
            exp_yx = (k == 1) ? 9'h000 : 9'h080;
            cyc(0, 1, dig, dig);
            vectors++;
            if (out_valid !== 1'b1 || x_d !== dig || y_d !== dig || last !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_beat%0d_ctrl: out_valid=%b x_d=%b y_d=%b last=%b want 1 %b %b 0", k, out_valid, x_d, y_d, last, dig, dig);
            end
            vectors++;
            if (yX_out !== exp_yx || xY_out !== 9'h080) begin
                miscompares++;
                $display("FAIL basic_beat%0d_ops: yX=%h xY=%h want %h 080", k, yX_out, xY_out, exp_yx);
            end
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_in_ready_flush: got %b want 0", in_ready);
        end
        for (int f = 0; f < DELTA; f++) begin
            cyc(0, 0, SD_POS, SD_POS);
            vectors++;
            if (out_valid !== 1'b1 || x_d !== SD_ZERO || y_d !== SD_ZERO || last !== (f == DELTA - 1)
                || yX_out !== 9'h080 || xY_out !== 9'h080) begin
                miscompares++;
                $display("FAIL basic_flush%0d: out_valid=%b x_d=%b y_d=%b last=%b yX=%h xY=%h want 1 00 00 %0d 080 080",
                         f, out_valid, x_d, y_d, last, yX_out, xY_out, (f == DELTA - 1));
            end
        end
        cyc(0, 0, SD_ZERO, SD_ZERO);
        vectors++;
        if (out_valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || yX_out !== 9'h080) begin
            miscompares++;
            $display("FAIL basic_done: out_valid=%b last=%b busy=%b yX=%h want 0 0 0 080", out_valid, last, busy, yX_out);
        end
    endtask

    task automatic test_borrow();
        logic [1:0]  xs[8]     = '{SD_NEG, SD_POS, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO};
        logic [1:0]  ys[8]     = '{SD_ZERO, SD_NEG, SD_POS, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_POS};
        logic [WL:0] exp_yx[8] = '{9'h000, 9'h180, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0};
        logic [WL:0] exp_xy[8] = '{9'h000, 9'h1C0, 9'h1E0, 9'h1E0, 9'h1E0, 9'h1E0, 9'h1E0, 9'h1E1};
        cyc(1, 0, SD_ZERO, SD_ZERO);
        for (int k = 0; k < WL; k++) begin
            cyc(0, 1, xs[k], ys[k]);
            vectors++;
            if (out_valid !== 1'b1 || yX_out !== exp_yx[k] || xY_out !== exp_xy[k]) begin
                miscompares++;
                $display("FAIL borrow_beat%0d: out_valid=%b yX=%h xY=%h want 1 %h %h", k + 1, out_valid, yX_out, xY_out, exp_yx[k], exp_xy[k]);
            end
        end
        for (int f = 0; f < DELTA; f++) begin
            cyc(0, 0, SD_ZERO, SD_ZERO);
            vectors++;
            if (out_valid !== 1'b1 || last !== (f == DELTA - 1) || yX_out !== 9'h1C0 || xY_out !== 9'h1E1) begin
                miscompares++;
                $display("FAIL borrow_flush%0d: out_valid=%b last=%b yX=%h xY=%h want 1 %0d 1c0 1e1", f, out_valid, last, yX_out, xY_out, (f == DELTA - 1));
            end
        end
        cyc(0, 0, SD_ZERO, SD_ZERO);
    endtask

    task automatic test_stall();
        logic [WL:0] exp_yx[8] = '{9'h000, 9'h080, 9'h0C0, 9'h0E0, 9'h0F0, 9'h0F8, 9'h0FC, 9'h0FE};
        logic [1:0]  ydig;
        int          beats = 0;
        cyc(1, 0, SD_ZERO, SD_ZERO);
        for (int k = 0; k < WL; k++) begin
            if (k == 3) begin
                for (int s = 0; s < 3; s++) begin
                    cyc(0, 0, SD_NEG, SD_NEG);
                    vectors++;
                    if (out_valid !== 1'b0 || in_ready !== 1'b1 || yX_out !== 9'h0C0 || xY_out !== 9'h080) begin
                        miscompares++;
                        $display("FAIL stall%0d: out_valid=%b in_ready=%b yX=%h xY=%h want 0 1 0c0 080", s, out_valid, in_ready, yX_out, xY_out);
                    end
                end
            end
            ydig = (k == 0) ? SD_POS : SD_ZERO;
            cyc(0, 1, SD_POS, ydig);
            if (out_valid === 1'b1) beats++;
            vectors++;
            if (yX_out !== exp_yx[k] || xY_out !== 9'h080) begin
                miscompares++;
                $display("FAIL stall_beat%0d: yX=%h xY=%h want %h 080", k + 1, yX_out, xY_out, exp_yx[k]);
            end
        end
        vectors++;
        if (beats !== WL || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_count: beats=%0d in_ready=%b want %0d 0", beats, in_ready, WL);
        end
        for (int f = 0; f < DELTA; f++) begin
            cyc(0, 0, SD_ZERO, SD_ZERO);
            vectors++;
            if (out_valid !== 1'b1 || last !== (f == DELTA - 1) || yX_out !== 9'h0FF || xY_out !== 9'h080) begin
                miscompares++;
                $display("FAIL stall_flush%0d: out_valid=%b last=%b yX=%h xY=%h want 1 %0d 0ff 080", f, out_valid, last, yX_out, xY_out, (f == DELTA - 1));
            end
        end
        cyc(0, 0, SD_ZERO, SD_ZERO);
    endtask

    task automatic test_abort();
        // start together with in_valid in IDLE: digit must be dropped.
        cyc(1, 1, SD_POS, SD_POS);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_idle_start: out_valid=%b busy=%b want 0 1", out_valid, busy);
        end
        cyc(0, 1, SD_NEG, SD_NEG);
        vectors++;
        if (out_valid !== 1'b1 || x_d !== SD_NEG || yX_out !== 9'h000 || xY_out !== 9'h180) begin
            miscompares++;
            $display("FAIL abort_first_digit: out_valid=%b x_d=%b yX=%h xY=%h want 1 01 000 180", out_valid, x_d, yX_out, xY_out);
        end
        for (int k = 1; k < WL; k++) cyc(0, 1, SD_ZERO, SD_ZERO);
        cyc(0, 0, SD_ZERO, SD_ZERO);
        vectors++;
        if (out_valid !== 1'b1 || last !== 1'b0 || yX_out !== 9'h180 || xY_out !== 9'h180) begin
            miscompares++;
            $display("FAIL abort_flush0: out_valid=%b last=%b yX=%h xY=%h want 1 0 180 180", out_valid, last, yX_out, xY_out);
        end
        // start in the last flush cycle: no last pulse, fresh product.
        cyc(1, 0, SD_ZERO, SD_ZERO);
        vectors++;
        if (out_valid !== 1'b0 || last !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_flush_start: out_valid=%b last=%b busy=%b in_ready=%b want 0 0 1 1", out_valid, last, busy, in_ready);
        end
        cyc(0, 1, SD_POS, SD_ZERO);
        vectors++;
        if (out_valid !== 1'b1 || x_d !== SD_POS || yX_out !== 9'h000 || xY_out !== 9'h000) begin
            miscompares++;
            $display("FAIL abort_restart_beat: out_valid=%b x_d=%b yX=%h xY=%h want 1 10 000 000", out_valid, x_d, yX_out, xY_out);
        end
        // start mid-LOAD with a valid digit: no beat, restart at j=1.
        cyc(1, 1, SD_NEG, SD_NEG);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_load_start: out_valid=%b want 0", out_valid);
        end
        cyc(0, 1, SD_ZERO, SD_POS);
        vectors++;
        if (out_valid !== 1'b1 || yX_out !== 9'h000 || xY_out !== 9'h080) begin
            miscompares++;
            $display("FAIL abort_load_restart: out_valid=%b yX=%h xY=%h want 1 000 080", out_valid, yX_out, xY_out);
        end
    endtask

    task automatic test_async_reset();
        cyc(0, 1, SD_POS, SD_POS);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, out_valid, in_ready, last} !== 4'b0 || yX_out !== '0 || xY_out !== '0) begin
            miscompares++;
            $display("FAIL async_rst: busy/out_valid/in_ready/last=%b yX=%h xY=%h want 0000 000 000", {busy, out_valid, in_ready, last}, yX_out, xY_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0, SD_ZERO, SD_ZERO);
        for (int k = 1; k <= 2; k++) begin
            cyc(0, 1, (k == 1) ? SD_POS : SD_ZERO, (k == 1) ? SD_POS : SD_ZERO);
            vectors++;
            if (out_valid !== 1'b1 || yX_out !== ((k == 1) ? 9'h000 : 9'h080) || xY_out !== 9'h080) begin
                miscompares++;
                $display("FAIL async_rst_rerun%0d: out_valid=%b yX=%h xY=%h want 1 %h 080", k, out_valid, yX_out, xY_out, (k == 1) ? 9'h000 : 9'h080);
            end
        end
    endtask

    task automatic test_illegal();
        logic [1:0] xd;
        logic       exp_err;
        cyc(1, 0, SD_ZERO, SD_ZERO);
        for (int k = 1; k <= WL; k++) begin
            xd      = (k == 1) ? SD_POS : ((k == 3) ? SD_ILL : SD_ZERO);
            exp_err = CHK && (k >= 3);
            cyc(0, 1, xd, (k == 1) ? SD_POS : SD_ZERO);
            vectors++;
            if (err !== exp_err || yX_out !== ((k == 1) ? 9'h000 : 9'h080) || xY_out !== 9'h080) begin
                miscompares++;
                $display("FAIL illegal_beat%0d: err=%b yX=%h xY=%h want %b %h 080", k, err, yX_out, xY_out, exp_err, (k == 1) ? 9'h000 : 9'h080);
            end
        end
        repeat (DELTA + 1) cyc(0, 0, SD_ZERO, SD_ZERO);
        vectors++;
        if (err !== CHK || yX_out !== 9'h080) begin
            miscompares++;
            $display("FAIL illegal_sticky: err=%b yX=%h want %b 080", err, yX_out, CHK);
        end
        cyc(1, 0, SD_ZERO, SD_ZERO);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_clear: err=%b want 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_stall();
        test_abort();
        test_async_reset();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
